// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter and its write queue.
package vram_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  // Records which requester owned the memory port in the last cycle.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DISP,
    ARB_WR
  } arb_state_e;

  // One queued VRAM write.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/vram_wq.sv
// Write queue: small synchronous FIFO with extended read/write pointers.
// The extra pointer MSB tells full from empty without a separate counter.
module vram_wq
  import vram_pkg::*;
#(
  parameter type entry_t = wr_req_t,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           din_i,
  output entry_t           dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] level_o
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  // Store an accepted entry at the write pointer.
  // NOTE: the storage array is not reset; the pointers alone say which slots hold live data.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem[wr_ptr_q[PTR_W-2:0]] <= din_i;
    end
  end

  // Advance the pointers on accepted push / pop; reset empties the queue.
  // NOTE: sequential state is always assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem[rd_ptr_q[PTR_W-2:0]];

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: the display read path has strict priority with a fixed
// one-cycle read latency; UART writes are queued and drain only on cycles
// the display leaves free. No forwarding: a display read of an address with
// a queued write returns the old contents, which the next frame corrects.
// Optional statistics (stall counter, overflow flag) with VRAM_ARB_STATS_EN.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int  ADDR_W   = DEF_ADDR_W,
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  WQ_DEPTH = 4,
  localparam int LVL_W    = $clog2(WQ_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [LVL_W-1:0]  wq_level_o
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic              ovf_o
`endif
);

  // Queue entry sized to this instance's address/data widths.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  arb_state_e state_q;
  arb_state_e state_d;
  req_t       wq_din;
  req_t       wq_head;
  logic       wq_full;
  logic       wq_empty;
  logic       wq_push;
  logic       wq_pop;

  // Per-cycle grant and memory port drive; everything is held at 0 in reset.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = ARB_IDLE;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst_i) begin
      if (disp_req_i) begin
        state_d    = ARB_DISP;
        mem_en_o   = 1'b1;
        mem_addr_o = disp_addr_i;
      end else if (!wq_empty) begin
        state_d     = ARB_WR;
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wq_head.addr;
        mem_wdata_o = wq_head.data;
      end
    end
  end

  // Last-grant register; a DISP grant here marks read data valid this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  assign disp_valid_o = (state_q == ARB_DISP);
  assign disp_data_o  = disp_valid_o ? mem_rdata_i : '0;

  // A full queue refuses pushes even if it pops this cycle; a fresh entry
  // is only visible at the head from the next cycle on.
  assign wr_ready_o = !wq_full && !rst_i;
  assign wq_push    = wr_valid_i && wr_ready_o;
  assign wq_pop     = (state_d == ARB_WR);
  assign wq_din     = '{addr: wr_addr_i, data: wr_data_i};

  vram_wq #(
    .entry_t (req_t),
    .DEPTH   (WQ_DEPTH)
  ) u_wq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wq_push),
    .pop_i   (wq_pop),
    .din_i   (wq_din),
    .dout_o  (wq_head),
    .full_o  (wq_full),
    .empty_o (wq_empty),
    .level_o (wq_level_o)
  );

`ifdef VRAM_ARB_STATS_EN
  // Count write stalls caused by display priority (saturating) and latch
  // any push attempt the queue had to refuse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      ovf_o       <= 1'b0;
    end else begin
      if (state_d == ARB_DISP && !wq_empty && stall_cnt_o != 16'hFFFF) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
      if (wr_valid_i && !wr_ready_o) begin
        ovf_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected memory writes
// and display read results into queues; a negedge monitor pops and compares.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        disp_req_i;
  logic [11:0] disp_addr_i;
  logic [7:0]  disp_data_o;
  logic        disp_valid_o;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [11:0] wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic [2:0]  wq_level_o;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {int cyc; logic [11:0] addr; logic [7:0] data;} wr_exp_t;
  typedef struct {int cyc; logic [7:0] data;} rd_exp_t;
  wr_exp_t exp_wr[$];
  rd_exp_t exp_rd[$];

  logic [7:0] vram [4096];

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .WQ_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .disp_req_i   (disp_req_i),
    .disp_addr_i  (disp_addr_i),
    .disp_data_o  (disp_data_o),
    .disp_valid_o (disp_valid_o),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .wq_level_o   (wq_level_o)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stall_cnt_o  (stall_cnt),
    .ovf_o        (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port VRAM with registered read data.
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) vram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i <= vram[mem_addr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every memory write and every valid read against the queues.
  always @(negedge clk) begin
    wr_exp_t we;
    rd_exp_t re;
    if (mem_en_o && mem_we_o) begin
      check("wr_while_disp", 32'(disp_req_i), 32'd0);
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wr: got write addr=%h data=%h at cycle %0d, required none",
                 mem_addr_o, mem_wdata_o, cyc);
      end else begin
        we = exp_wr.pop_front();
        check("wr_cycle", 32'(cyc), 32'(we.cyc));
        check("wr_addr", 32'(mem_addr_o), 32'(we.addr));
        check("wr_data", 32'(mem_wdata_o), 32'(we.data));
      end
    end
    if (disp_valid_o) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd: got valid data=%h at cycle %0d, required none",
                 disp_data_o, cyc);
      end else begin
        re = exp_rd.pop_front();
        check("rd_cycle", 32'(cyc), 32'(re.cyc));
        check("rd_data", 32'(disp_data_o), 32'(re.data));
      end
    end else begin
      check("rd_data_idle", 32'(disp_data_o), 32'd0);
    end
  end

  initial begin
    int p;
    int q;
    rst_i       = 1'b1;
    disp_req_i  = 1'b1;
    disp_addr_i = 12'h0AA;
    wr_valid_i  = 1'b1;
    wr_addr_i   = 12'h0;
    wr_data_i   = 8'h0;
    for (int i = 0; i < 4096; i++) vram[i] = 8'h00;
    vram[12'h123] = 8'h5A;
    for (int i = 0; i < 10; i++) vram[12'h200 + 12'(i)] = 8'h40 + 8'(i);
    vram[12'h400] = 8'h77;
    vram[12'h600] = 8'h33;

    // Reset: requests present, yet every output stays 0.
    repeat (2) tick();
    check("rst_mem_en", 32'(mem_en_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    check("rst_wr_ready", 32'(wr_ready_o), 32'd0);
    check("rst_level", 32'(wq_level_o), 32'd0);
    check("rst_disp_valid", 32'(disp_valid_o), 32'd0);

    tick();
    rst_i      = 1'b0;
    disp_req_i = 1'b0;
    wr_valid_i = 1'b0;
    #1;
    check("rel_wr_ready", 32'(wr_ready_o), 32'd1);
    check("rel_mem_en", 32'(mem_en_o), 32'd0);

    // Idle write: pushed entry reaches memory the following cycle.
    tick();
    wr_valid_i = 1'b1;
    wr_addr_i  = 12'h010;
    wr_data_i  = 8'hAB;
    exp_wr.push_back('{cyc + 1, 12'h010, 8'hAB});
    #1;
    check("idle_same_cycle_we", 32'(mem_we_o), 32'd0);
    tick();
    wr_valid_i = 1'b0;
    #1;
    check("idle_level1", 32'(wq_level_o), 32'd1);
    check("idle_we", 32'(mem_we_o), 32'd1);
    tick();
    check("idle_level0", 32'(wq_level_o), 32'd0);

    // Read latency: data valid exactly one cycle after the grant.
    tick();
    disp_req_i  = 1'b1;
    disp_addr_i = 12'h123;
    exp_rd.push_back('{cyc + 1, 8'h5A});
    #1;
    check("rd_grant_addr", 32'(mem_addr_o), 32'h123);
    check("rd_grant_we", 32'(mem_we_o), 32'd0);
    tick();
    disp_req_i = 1'b0;
    check("rd_valid", 32'(disp_valid_o), 32'd1);
    check("rd_value", 32'(disp_data_o), 32'h5A);
    tick();
    check("rd_valid_drop", 32'(disp_valid_o), 32'd0);

    // Display priority: 10 read cycles, 4 writes queued, one refused push.
    p = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) p = cyc;
      disp_req_i  = 1'b1;
      disp_addr_i = 12'h200 + 12'(i);
      exp_rd.push_back('{cyc + 1, 8'h40 + 8'(i)});
      if (i < 4) begin
        wr_valid_i = 1'b1;
        wr_addr_i  = 12'h300 + 12'(i);
        wr_data_i  = 8'hC0 + 8'(i);
        exp_wr.push_back('{p + 10 + i, 12'h300 + 12'(i), 8'hC0 + 8'(i)});
      end else if (i == 4) begin
        wr_valid_i = 1'b1;
        wr_addr_i  = 12'h3FF;
        wr_data_i  = 8'hEE;
        #1;
        check("prio_full_ready", 32'(wr_ready_o), 32'd0);
        check("prio_full_level", 32'(wq_level_o), 32'd4);
      end else begin
        wr_valid_i = 1'b0;
      end
    end
    tick();
    disp_req_i = 1'b0;
    wr_valid_i = 1'b0;
`ifdef VRAM_ARB_STATS_EN
    check("stats_stall9", 32'(stall_cnt), 32'd9);
    check("stats_ovf_set", 32'(ovf), 32'd1);
`endif
    repeat (4) tick();
    check("prio_drained", 32'(wq_level_o), 32'd0);
    check("prio_ready", 32'(wr_ready_o), 32'd1);

    // Interleave: fill under display, then toggle; writes only in 0 cycles.
    q = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) q = cyc;
      disp_req_i  = 1'b1;
      disp_addr_i = 12'h400;
      exp_rd.push_back('{cyc + 1, 8'h77});
      wr_valid_i  = 1'b1;
      wr_addr_i   = 12'h500 + 12'(i);
      wr_data_i   = 8'h10 + 8'(i);
      exp_wr.push_back('{q + 4 + 2 * i, 12'h500 + 12'(i), 8'h10 + 8'(i)});
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      wr_valid_i = 1'b0;
      disp_req_i = k[0];
      if (k[0]) begin
        exp_rd.push_back('{cyc + 1, 8'h77});
        if (k <= 7) begin
          wr_valid_i = 1'b1;
          wr_addr_i  = 12'h500 + 12'(4 + k / 2);
          wr_data_i  = 8'h10 + 8'(4 + k / 2);
          exp_wr.push_back('{q + 4 + 2 * (4 + k / 2), 12'h500 + 12'(4 + k / 2),
                             8'h10 + 8'(4 + k / 2)});
          #1;
          check("ilv_ready", 32'(wr_ready_o), 32'd1);
        end
      end else if (k == 0) begin
        #1;
        check("ilv_full_ready", 32'(wr_ready_o), 32'd0);
      end
    end
    tick();
    disp_req_i = 1'b0;
    wr_valid_i = 1'b0;
    #1;
    check("ilv_level0", 32'(wq_level_o), 32'd0);
`ifdef VRAM_ARB_STATS_EN
    check("stats_ovf_sticky", 32'(ovf), 32'd1);
`endif

    // Reset mid-operation with 3 entries queued.
    for (int i = 0; i < 4; i++) begin
      tick();
      disp_req_i  = 1'b1;
      disp_addr_i = 12'h600;
      if (i < 2) exp_rd.push_back('{cyc + 1, 8'h33});
      if (i < 3) begin
        wr_valid_i = 1'b1;
        wr_addr_i  = 12'h700 + 12'(i);
        wr_data_i  = 8'h50 + 8'(i);
      end else begin
        wr_valid_i = 1'b0;
      end
    end
    #1;
    check("mid_level3", 32'(wq_level_o), 32'd3);
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_mem_en", 32'(mem_en_o), 32'd0);
    check("mid_rst_level", 32'(wq_level_o), 32'd0);
    check("mid_rst_ready", 32'(wr_ready_o), 32'd0);
    check("mid_rst_valid", 32'(disp_valid_o), 32'd0);
    tick();
    disp_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    #1;
    check("mid_rel_ready", 32'(wr_ready_o), 32'd1);
    check("mid_rel_level", 32'(wq_level_o), 32'd0);
`ifdef VRAM_ARB_STATS_EN
    check("stats_stall_clr", 32'(stall_cnt), 32'd0);
    check("stats_ovf_clr", 32'(ovf), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flushed_no_we", 32'(mem_we_o), 32'd0);
    end

    tick();
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM between two requesters: the VGA pixel-fetch path and the UART-fed write path (bytes decoded from rx_i).
- The display path has strict priority and a fixed 1-cycle read latency, so the PMOD output never glitches.
- Writes go into a small FIFO and drain only on cycles the display does not claim.
- Sits between the UART command decoder, the VGA timing/pixel logic and the VRAM macro inside top.

Parameters:
- ADDR_W, 12, VRAM address width
- DATA_W, 8, VRAM data width
- WQ_DEPTH, 4, write-queue entries; power of two, at least 2

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- disp_req_i  in  1  display read request this cycle
- disp_addr_i  in  ADDR_W  display read address
- disp_data_o  out  DATA_W  read data, valid one cycle after the grant
- disp_valid_o  out  1  disp_data_o is valid
- wr_valid_i  in  1  write request from the UART decoder
- wr_ready_o  out  1  write queue can accept an entry
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- mem_en_o  out  1  VRAM enable
- mem_we_o  out  1  VRAM write enable
- mem_addr_o  out  ADDR_W  VRAM address
- mem_wdata_o  out  DATA_W  VRAM write data
- mem_rdata_i  in  DATA_W  VRAM read data, registered, 1-cycle latency
- wq_level_o  out  $clog2(WQ_DEPTH)+1  write-queue occupancy

Behaviour:
- Reset (async assert, sync release): all outputs 0 and the FIFO is empty. wr_ready_o is 0 while rst_i=1 and 1 on the first cycle after release. State is IDLE.
- Memory port outputs are combinational from the current-cycle grant. The grant is decided each cycle:
  - disp_req_i=1: DISP grant. mem_en_o=1, mem_we_o=0, mem_addr_o=disp_addr_i.
  - else FIFO non-empty: WR grant. mem_en_o=1, mem_we_o=1, addr/data from the FIFO head, head popped at the clock edge.
  - else idle: all mem outputs 0.
- disp_valid_o is a register: it equals 1 in cycle N+1 iff DISP was granted in cycle N. disp_data_o = mem_rdata_i while valid, 0 otherwise.
- Enqueue handshake: an entry is pushed when wr_valid_i & wr_ready_o. wr_ready_o = !full, combinational from the level.
- Simultaneous push and pop:
  - When full, a pop and push in the same cycle is not allowed; the push waits because ready=0.
  - When empty, a pushed entry is not written in the same cycle; the earliest possible write is the next cycle.
- FSM state register (IDLE, DISP, WR) records the last grant for the stats and debug paths. DISP→WR→DISP alternation per cycle is legal.
- Same-address hazard: a display read of an address with a pending queued write returns the old memory contents. No forwarding is done, by design, because the next frame corrects it.
- Reset mid-operation: the FIFO is flushed, pending writes are lost and the in-flight read valid is cleared.
- Pointer wrap: ADDR_W-independent read and write pointers of $clog2(WQ_DEPTH)+1 bits. Full = MSBs differ and the rest are equal.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds outputs stall_cnt_o[15:0] and ovf_o.
  - stall_cnt_o increments on each cycle with FIFO non-empty and a DISP grant, and saturates at 16'hFFFF.
  - ovf_o is sticky and sets when wr_valid_i=1 with wr_ready_o=0.
  - Both clear only on rst_i.
- When undefined, these ports and their logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package vram_pkg:
  - arb_state_e (ARB_IDLE, ARB_DISP, ARB_WR)
  - default ADDR_W / DATA_W localparams
  - packed struct wr_req_t {addr, data}
- Sub-module: vram_wq, a parameterised synchronous FIFO of wr_req_t with push/pop/full/empty/level. The arbiter instantiates one copy.

Test Plan:
- Reset behaviour: assert rst_i mid-cycle with 3 entries queued → outputs 0 immediately and level 0; after release, wr_ready_o=1 and no mem write occurs.
- Idle write: no display requests, push (0x010,0xAB) → next cycle mem_we_o=1, addr 0x010, data 0xAB; level returns to 0.
- Display priority: disp_req_i held high for 10 cycles while 4 writes are pushed → zero mem writes, wr_ready_o=0 after the 4th, disp_valid_o high for cycles 2–11. Then drop disp_req_i → 4 writes in order on 4 consecutive cycles.
- Read latency: disp at 0x123 with the memory model returning 0x5A → disp_valid_o=1 and disp_data_o=0x5A exactly one cycle later.
- Interleave: disp_req_i toggling 1/0 with the FIFO full → writes occur only in the 0 cycles; FIFO order is preserved, checked against a scoreboard.
- Stats (VRAM_ARB_STATS_EN): the priority scenario gives stall_cnt_o=9; a push attempt while full sets ovf_o, which stays set until reset.
